// File: rtl/run_sequencer.sv
// run_sequencer: host-side run controller for the processor top level.
// A host request becomes a timed core reset pulse followed by a run window.
// The window closes on the core's done flag or on a watchdog limit.
// The host then sees a registered acknowledge, the run length in cycles and
// whether the watchdog ended the run.
module run_sequencer #(
    parameter int INIT_CYCLES = 2,
    parameter int TIMEOUT     = 100000,
    parameter int CW          = 32
) (
    input  logic          clk,
    input  logic          init,
    input  logic          host_req,
    input  logic          core_ack,
    output logic          core_init,
    output logic          core_req,
    output logic          host_ack,
    output logic          busy,
    output logic [CW-1:0] cycle_count,
    output logic          timeout
);

    // The init counter only has to count down INIT_CYCLES-1 .. 0.
    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [IW-1:0] INIT_LOAD = IW'(INIT_CYCLES - 1);
    // This is the count value seen during the final RUN cycle the watchdog allows.
    localparam logic [CW-1:0] LAST_RUN = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        INIT_CORE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] initCount;

    // Single Moore FSM.
    // Every output is written on the same edge as the state it belongs to, so
    // the outputs are registered and match the state visible in that cycle.
    always_ff @(posedge clk) begin
        if (init) begin
            state       <= IDLE;
            initCount   <= '0;
            core_init   <= 1'b0;
            core_req    <= 1'b0;
            host_ack    <= 1'b0;
            busy        <= 1'b0;
            cycle_count <= '0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (host_req) begin
                        state       <= INIT_CORE;
                        initCount   <= INIT_LOAD;
                        core_init   <= 1'b1;
                        busy        <= 1'b1;
                        cycle_count <= '0;
                        timeout     <= 1'b0;
                    end
                end
                INIT_CORE: begin
                    // The core's ack is stale while it is held in reset, so it is ignored here.
                    if (initCount == '0) begin
                        state     <= RUN;
                        core_init <= 1'b0;
                        core_req  <= 1'b1;
                    end else begin
                        initCount <= initCount - 1'b1;
                    end
                end
                RUN: begin
                    cycle_count <= cycle_count + 1'b1;
                    if (core_ack) begin
                        state    <= DONE;
                        core_req <= 1'b0;
                        busy     <= 1'b0;
                        host_ack <= 1'b1;
                    end else if (cycle_count == LAST_RUN) begin
                        state    <= DONE;
                        core_req <= 1'b0;
                        busy     <= 1'b0;
                        host_ack <= 1'b1;
                        timeout  <= 1'b1;
                    end
                end
                DONE: begin
                    // core_init stays low so the host can still read the core's memory.
                    if (!host_req) begin
                        state    <= IDLE;
                        host_ack <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    core_init <= 1'b0;
                    core_req  <= 1'b0;
                    host_ack  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed and randomized runs of run_sequencer.
// Expected values come from a run-level model.
// The run length is the first ack cycle, or TIMEOUT when no ack arrives in time.
module tb_run_sequencer;

    localparam int INIT_CYCLES = 2;
    localparam int TIMEOUT     = 16;
    localparam int CW          = 32;

    logic          clk = 1'b0;
    logic          init = 1'b1;
    logic          host_req = 1'b0;
    logic          core_ack = 1'b0;
    logic          core_init;
    logic          core_req;
    logic          host_ack;
    logic          busy;
    logic [CW-1:0] cycle_count;
    logic          timeout;

    int            checkCount = 0;
    int            passCount  = 0;
    logic [CW-1:0] lastCount  = '0;
    logic          lastTimeout = 1'b0;

    run_sequencer #(
        .INIT_CYCLES(INIT_CYCLES),
        .TIMEOUT(TIMEOUT),
        .CW(CW)
    ) dut (
        .clk(clk),
        .init(init),
        .host_req(host_req),
        .core_ack(core_ack),
        .core_init(core_init),
        .core_req(core_req),
        .host_ack(host_ack),
        .busy(busy),
        .cycle_count(cycle_count),
        .timeout(timeout)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "[TB] time limit expired");
    end

    task automatic applyStimulus(input logic req, input logic ack);
        host_req = req;
        core_ack = ack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic eInit, input logic eReq,
                               input logic eAck, input logic eBusy, input logic eTo,
                               input logic [CW-1:0] eCount);
        logic [CW+4:0] obs;
        logic [CW+4:0] exp;
        obs = {core_init, core_req, host_ack, busy, timeout, cycle_count};
        exp = {eInit, eReq, eAck, eBusy, eTo, eCount};
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s observed init=%b req=%b ack=%b busy=%b to=%b count=%0d expected init=%b req=%b ack=%b busy=%b to=%b count=%0d",
                   tag, core_init, core_req, host_ack, busy, timeout, cycle_count,
                   eInit, eReq, eAck, eBusy, eTo, eCount);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput(tag, 1'b0, 1'b0, 1'b0, 1'b0, lastTimeout, lastCount);
    endtask

    // A firstAck of 0 or of a value above TIMEOUT means the core never acks.
    // A dropAt of 0 means the request is not dropped during RUN.
    task automatic doRun(input string name, input int firstAck, input bit staleAck,
                         input int dropAt, input int holdCycles, input int idleCycles);
        int expN;
        bit expTo;
        if (firstAck >= 1 && firstAck <= TIMEOUT) begin
            expN  = firstAck;
            expTo = 1'b0;
        end else begin
            expN  = TIMEOUT;
            expTo = 1'b1;
        end

        applyStimulus(1'b1, staleAck);
        tick();
        for (int c = 1; c <= INIT_CYCLES; c++) begin
            checkOutput({name, "_init"}, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
            core_ack = staleAck;
            tick();
        end
        for (int i = 1; i <= TIMEOUT; i++) begin
            checkOutput({name, "_run"}, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, CW'(i - 1));
            core_ack = (i == firstAck);
            if (i == dropAt) host_req = 1'b0;
            tick();
            if (i == expN) break;
        end
        lastCount   = CW'(expN);
        lastTimeout = expTo;
        core_ack    = 1'($urandom_range(0, 1));
        checkOutput({name, "_done"}, 1'b0, 1'b0, 1'b1, 1'b0, lastTimeout, lastCount);

        if (host_req) begin
            for (int h = 0; h < holdCycles; h++) begin
                core_ack = 1'($urandom_range(0, 1));
                tick();
                checkOutput({name, "_hold"}, 1'b0, 1'b0, 1'b1, 1'b0, lastTimeout, lastCount);
            end
            host_req = 1'b0;
        end
        tick();
        checkIdle({name, "_release"});
        for (int d = 0; d < idleCycles; d++) begin
            core_ack = 1'($urandom_range(0, 1));
            tick();
            checkIdle({name, "_idle"});
        end
    endtask

    initial begin
        $display("[TB] run_sequencer bench start");
        applyStimulus(1'b0, 1'b0);
        init = 1'b1;
        tick();
        tick();
        checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        init = 1'b0;

        for (int t = 0; t < 10; t++) begin
            applyStimulus(1'b0, 1'(t % 2));
            tick();
            checkIdle("idle_ack_toggle");
        end

        doRun("normal", 7, 1'b0, 0, 2, 1);
        doRun("stale_ack", 3, 1'b1, 0, 0, 0);
        doRun("watchdog", 0, 1'b0, 0, 1, 2);
        doRun("ack_at_limit", TIMEOUT, 1'b0, 0, 0, 1);
        doRun("ack_first", 1, 1'b1, 0, 0, 0);
        doRun("drop_in_run", 5, 1'b0, 2, 0, 1);
        doRun("hold_in_done", 4, 1'b0, 0, 4, 0);

        // A reset in the middle of a run aborts it on the next edge.
        applyStimulus(1'b1, 1'b0);
        tick();
        for (int c = 1; c <= INIT_CYCLES; c++) begin
            checkOutput("abort_init", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
            tick();
        end
        for (int i = 1; i <= 4; i++) begin
            checkOutput("abort_run", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, CW'(i - 1));
            if (i == 4) begin
                init     = 1'b1;
                host_req = 1'b0;
            end
            tick();
        end
        lastCount   = '0;
        lastTimeout = 1'b0;
        checkOutput("abort_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        init = 1'b0;
        tick();
        checkIdle("abort_idle");
        doRun("after_abort", 6, 1'b0, 0, 1, 1);

        for (int r = 0; r < 25; r++) begin
            int fa;
            int da;
            fa = int'($urandom_range(0, TIMEOUT + 2));
            da = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, TIMEOUT)) : 0;
            doRun("random", fa, 1'($urandom_range(0, 1)), da,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
